// File: rtl/mmcm_phase_shift_ctrl.sv
// Converts a requested fine delay (ps) into MMCM phase steps and walks the
// MMCM dynamic phase-shift port there one PSEN/PSDONE handshake at a time.
module mmcm_phase_shift_ctrl #(
    parameter int STEP_PS        = 18,
    parameter int MAX_DELAY_PS   = 999,
    parameter int PSDONE_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] fine_delay_ps,
    input  logic        fine_update,
    input  logic        mmcm_locked,
    input  logic        psdone,
    output logic        psen,
    output logic        psincdec,
    output logic        busy,
    output logic        done,
    output logic [15:0] applied_delay_ps,
    output logic        clamped,
    output logic        timeout_err
);

    localparam logic [15:0] STEP_W  = 16'(STEP_PS);
    localparam logic [15:0] MAX_W   = 16'(MAX_DELAY_PS);
    localparam int          TW      = $clog2(PSDONE_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(PSDONE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_WAIT_LOCK, S_IDLE, S_DIVIDE, S_COMPARE, S_PULSE, S_WAIT_DONE, S_FINISH
    } state_t;

    state_t        state_q, state_d;
    logic [6:0]    cur_q, cur_d;
    logic [6:0]    tgt_q, tgt_d;
    logic [15:0]   rem_q, rem_d;
    logic [15:0]   req_q, req_d;
    logic [15:0]   pend_q, pend_d;
    logic          pend_vld_q, pend_vld_d;
    logic          dir_q, dir_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [15:0]   applied_q, applied_d;
    logic          clamped_q, clamped_d;
    logic          terr_q, terr_d;
    logic [15:0]   acc_val;
    logic          in_flight;

    assign in_flight = (state_q == S_DIVIDE) || (state_q == S_COMPARE) ||
                       (state_q == S_PULSE)  || (state_q == S_WAIT_DONE);

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        tgt_d      = tgt_q;
        rem_d      = rem_q;
        req_d      = req_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        dir_d      = dir_q;
        tcnt_d     = tcnt_q;
        clamped_d  = clamped_q;
        terr_d     = terr_q;
        acc_val    = fine_update ? fine_delay_ps : pend_q;
        applied_d  = 16'(cur_q) * STEP_W;

        // Anything not accepted directly from IDLE queues up; last write wins.
        if (fine_update) begin
            pend_d     = fine_delay_ps;
            pend_vld_d = 1'b1;
        end

        if (!mmcm_locked) begin
            // Relock resets MMCM phase, so our step count restarts at zero.
            state_d = S_WAIT_LOCK;
            cur_d   = '0;
            if (!fine_update && in_flight && !pend_vld_q) begin
                pend_d     = req_q;
                pend_vld_d = 1'b1;
            end
        end else begin
            case (state_q)
                S_WAIT_LOCK: state_d = S_IDLE;
                S_IDLE: begin
                    if (fine_update || pend_vld_q) begin
                        pend_vld_d = 1'b0;
                        req_d      = acc_val;
                        clamped_d  = acc_val > MAX_W;
                        rem_d      = (acc_val > MAX_W) ? MAX_W : acc_val;
                        tgt_d      = '0;
                        terr_d     = 1'b0;
                        state_d    = S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    if (rem_q >= STEP_W) begin
                        rem_d = rem_q - STEP_W;
                        tgt_d = tgt_q + 7'd1;
                    end else begin
                        if ({rem_q, 1'b0} >= {1'b0, STEP_W}) tgt_d = tgt_q + 7'd1;
                        state_d = S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (tgt_q == cur_q) begin
                        state_d = S_FINISH;
                    end else begin
                        dir_d   = tgt_q > cur_q;
                        state_d = S_PULSE;
                    end
                end
                S_PULSE: begin
                    tcnt_d  = '0;
                    state_d = S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    // psdone takes priority over a timeout in the same cycle.
                    if (psdone) begin
                        cur_d   = dir_q ? cur_q + 7'd1 : cur_q - 7'd1;
                        state_d = S_COMPARE;
                    end else if (tcnt_q == TO_LAST) begin
                        terr_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                S_FINISH: state_d = S_IDLE;
                default:  state_d = S_WAIT_LOCK;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_WAIT_LOCK;
            cur_q      <= '0;
            tgt_q      <= '0;
            rem_q      <= '0;
            req_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            dir_q      <= 1'b0;
            tcnt_q     <= '0;
            applied_q  <= '0;
            clamped_q  <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            tgt_q      <= tgt_d;
            rem_q      <= rem_d;
            req_q      <= req_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            dir_q      <= dir_d;
            tcnt_q     <= tcnt_d;
            applied_q  <= applied_d;
            clamped_q  <= clamped_d;
            terr_q     <= terr_d;
        end
    end

    assign psen             = mmcm_locked && (state_q == S_PULSE);
    assign psincdec         = psen && dir_q;
    assign done             = mmcm_locked && (state_q == S_FINISH);
    // FINISH is not busy, so done coincides with busy falling; a queued request
    // raises busy again in the following IDLE cycle.
    assign busy             = mmcm_locked && (in_flight || (state_q == S_IDLE && pend_vld_q));
    assign applied_delay_ps = applied_q;
    assign clamped          = clamped_q;
    assign timeout_err      = terr_q;

endmodule

// File: doc/mmcm_phase_shift_ctrl.md
# mmcm_phase_shift_ctrl

Sequencer for the MMCM dynamic phase-shift port behind the fine trigger-delay path. It accepts a requested fine delay in picoseconds and converts it to an MMCM phase-step count, rounded to nearest. It then issues one PSEN increment/decrement pulse at a time, waiting for PSDONE after each, until the MMCM phase matches the request. It also tracks the applied delay, handles loss of lock and guards against a missing PSDONE.

## Interface
Parameters:
- STEP_PS, 18 — picoseconds per MMCM phase step (VCO period / 56); must be ≥ 1.
- MAX_DELAY_PS, 999 — requests above this are clamped to it.
- PSDONE_TIMEOUT, 64 — clk cycles to wait for psdone after a psen pulse.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- clk  in  1  — system clock, also drives MMCM PSCLK.
- rst_n  in  1  — synchronous, active-low reset.
- fine_delay_ps  in  16  — requested delay; sampled only on fine_update.
- fine_update  in  1  — single-cycle request strobe.
- mmcm_locked  in  1  — MMCM LOCKED.
- psdone  in  1  — MMCM PSDONE, one-cycle pulse.
- psen  out  1  — MMCM PSEN, one-cycle pulse.
- psincdec  out  1  — 1 = increment, 0 = decrement; valid while psen is high.
- busy  out  1  — high from request acceptance until done.
- done  out  1  — one-cycle pulse when the target is reached.
- applied_delay_ps  out  16  — current_steps × STEP_PS.
- clamped  out  1  — last accepted request exceeded MAX_DELAY_PS.
- timeout_err  out  1  — sticky; psdone was missing.

## Operation
- Internal registers: current_steps (7 bits, 0..MAX_DELAY_PS/STEP_PS+1), target_steps, remainder (16 bits), pending request (value plus flag).
- States and transitions:
  - WAIT_LOCK → IDLE when mmcm_locked=1.
  - IDLE → DIVIDE on fine_update or pending flag.
  - DIVIDE: remainder starts as min(fine_delay_ps, MAX_DELAY_PS), target_steps = 0. Each cycle, while remainder ≥ STEP_PS: subtract STEP_PS and increment target_steps. When remainder < STEP_PS: add 1 to target_steps if 2·remainder ≥ STEP_PS, then go to COMPARE.
  - COMPARE:
    - target = current → FINISH.
    - Otherwise → PULSE, with psincdec = (target > current).
  - PULSE: psen=1 for exactly one cycle → WAIT_DONE.
  - WAIT_DONE:
    - On psdone: current_steps ±1 → COMPARE.
    - After PSDONE_TIMEOUT cycles: set timeout_err, leave current_steps unchanged → IDLE, with no done pulse.
  - FINISH: done=1 for one cycle → IDLE.
- fine_update while busy: the value is latched into pending; last write wins. It is serviced on return to IDLE.
- A new accepted request clears timeout_err and updates clamped.
- mmcm_locked falling in any state:
  - abort immediately; psen forced 0;
  - current_steps cleared to 0, because an MMCM relock resets phase;
  - a request in progress is kept as pending → WAIT_LOCK;
  - no done pulse.
- Arithmetic is unsigned. applied_delay_ps is registered and updates the cycle after current_steps changes.

## Timing
- Reset (rst_n=0 at a clk edge) forces WAIT_LOCK, and all of the following are 0: psen, psincdec, busy, done, applied_delay_ps, clamped, timeout_err, current_steps, pending.
- busy rises the cycle after fine_update is sampled in IDLE.
- DIVIDE takes floor(min(req, MAX)/STEP_PS) + 1 cycles.
- Each step costs PULSE (1 cycle) + WAIT_DONE (psdone latency) + COMPARE (1 cycle).
- psen never reasserts before psdone or timeout for the previous pulse.
- If psdone arrives in the same cycle a timeout would fire, psdone wins.
- psdone outside WAIT_DONE is ignored.
- done and the busy fall occur in the same cycle. The pending request re-raises busy on the next cycle.
- A request equal to current_steps yields busy for DIVIDE+COMPARE+FINISH cycles, zero psen pulses, and one done pulse.

## Test plan
All scenarios use the default parameters. The bench models PSDONE 12 cycles after PSEN.

- Lock, request 100 ps → 6 psen pulses, all with psincdec=1; applied_delay_ps=108; one done pulse; clamped=0.
- Then request 500 ps → 22 increment pulses; applied=504. Then request 0 → 28 decrement pulses; applied=0.
- Request 2000 ps → clamped=1; 56 increment pulses; applied=1008.
- Bench suppresses psdone on the 3rd pulse of a 100 ps request → timeout_err=1 after 64 cycles; applied=36; no done. Next request of 0 clears timeout_err and issues 2 decrement pulses.
- Issue 100 ps, then 500 ps while busy → the first completes (done, applied=108); busy reasserts the next cycle; the second finishes at 504 with exactly 2 done pulses total.
- Drop mmcm_locked mid-sequence at 300 ps → psen stops and applied=0. When lock returns, the request resumes from 0 and ends at applied=306 (17 steps). rst_n=0 mid-sequence → all outputs 0 the next cycle.
